// File: rtl/bl_pkg.sv
// rtl/bl_pkg.sv - shared constants and sequencer state type for the backlight zone scheduler
package bl_pkg;
    localparam int ZONES   = 360;
    localparam int ZONE_AW = 9;
    localparam int GRAY_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        SEND,
        DONE
    } seq_state_t;
endpackage

// File: rtl/bl_zone_dpram.sv
// rtl/bl_zone_dpram.sv - two-bank zone RAM, one write port, one registered read port, no reset
module bl_zone_dpram
    import bl_pkg::*;
(
    input  logic               clk,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [ZONE_AW-1:0] wr_idx,
    input  logic [GRAY_W-1:0]  wr_data,
    input  logic               rd_bank,
    input  logic [ZONE_AW-1:0] rd_idx,
    output logic [GRAY_W-1:0]  rd_data
);
    // Bank bit is the outer (most significant) address dimension.
    logic [GRAY_W-1:0] mem [0:1][0:ZONES-1];
    logic [GRAY_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
        rd_data_q <= mem[rd_bank][rd_idx];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/bl_zone_scheduler.sv
// rtl/bl_zone_scheduler.sv - ping-pong zone capture and valid/ready frame streamer for the LED driver
module bl_zone_scheduler
    import bl_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic               i_pix_clk,
    input  logic               rst,
    input  logic               r_Vsync_0,
    input  logic               flag_done,
    input  logic [ZONE_AW-1:0] cnt_360,
    input  logic [GRAY_W-1:0]  buf_360,
    input  logic               tx_en,
    output logic               o_zone_valid,
    input  logic               o_zone_ready,
    output logic [ZONE_AW-1:0] o_zone_idx,
    output logic [GRAY_W-1:0]  o_zone_data,
    output logic               o_zone_last,
    output logic               o_frame_done,
    output logic               o_busy,
    output logic               o_short_err,
    output logic               o_idx_err,
    output logic [DROP_W-1:0]  o_drop_cnt
);
    localparam logic [ZONE_AW-1:0] ZONES_V  = ZONE_AW'(ZONES);
    localparam logic [ZONE_AW-1:0] LAST_IDX = ZONE_AW'(ZONES - 1);

    seq_state_t         state_q, state_d;
    logic               vs_q, vs_d;
    logic [ZONE_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic               wr_bank_q, wr_bank_d;
    logic [ZONE_AW-1:0] idx_q, idx_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               short_q, short_d;
    logic               idx_err_q, idx_err_d;

    logic               vs_rise;
    logic               wr_ok;
    logic [ZONE_AW-1:0] wr_cnt_inc;
    logic               frame_full;
    logic               launch;
    logic               drop;
    logic               valid;
    logic               last;
    logic               frame_done;
    logic [ZONE_AW-1:0] rd_idx;
    logic [GRAY_W-1:0]  rd_data;

    // A strobe coinciding with the boundary is folded into wr_cnt_inc before the completeness test.
    always_comb begin
        vs_rise    = r_Vsync_0 & ~vs_q;
        wr_ok      = flag_done && (cnt_360 < ZONES_V);
        wr_cnt_inc = (wr_ok && (wr_cnt_q != '1)) ? wr_cnt_q + ZONE_AW'(1) : wr_cnt_q;
        frame_full = (wr_cnt_inc == ZONES_V);
        launch     = vs_rise && frame_full && tx_en && (state_q == IDLE);
        drop       = vs_rise && frame_full && (state_q != IDLE);

        vs_d      = r_Vsync_0;
        wr_cnt_d  = vs_rise ? '0 : wr_cnt_inc;
        wr_bank_d = wr_bank_q ^ launch;
        drop_d    = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
        short_d   = vs_rise && !frame_full;
        idx_err_d = flag_done && !(cnt_360 < ZONES_V);
    end

    // Stalled beats re-read the same address; the read bank is never written, so data holds.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid      = 1'b0;
        frame_done = 1'b0;
        rd_idx     = idx_q;
        last       = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = LAUNCH;
                    idx_d   = '0;
                end
            end
            LAUNCH: begin
                state_d = SEND;
            end
            SEND: begin
                valid = 1'b1;
                last  = (idx_q == LAST_IDX);
                if (o_zone_ready) begin
                    if (last) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d  = idx_q + ZONE_AW'(1);
                        rd_idx = idx_q + ZONE_AW'(1);
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_pix_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vs_q      <= 1'b0;
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            idx_q     <= '0;
            drop_q    <= '0;
            short_q   <= 1'b0;
            idx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_q      <= vs_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
            short_q   <= short_d;
            idx_err_q <= idx_err_d;
        end
    end

    bl_zone_dpram u_ram (
        .clk     (i_pix_clk),
        .wr_en   (wr_ok),
        .wr_bank (wr_bank_q),
        .wr_idx  (cnt_360),
        .wr_data (buf_360),
        .rd_bank (~wr_bank_q),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign o_zone_valid = valid;
    assign o_zone_idx   = idx_q;
    assign o_zone_data  = valid ? rd_data : '0;
    assign o_zone_last  = last;
    assign o_frame_done = frame_done;
    assign o_busy       = (state_q != IDLE);
    assign o_short_err  = short_q;
    assign o_idx_err    = idx_err_q;
    assign o_drop_cnt   = drop_q;
endmodule

// File: tb/tb_bl_zone_scheduler.sv
// tb/tb_bl_zone_scheduler.sv - directed scoreboard bench for bl_zone_scheduler
module tb_bl_zone_scheduler;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          r_Vsync_0;
    logic          flag_done;
    logic [8:0]    cnt_360;
    logic [7:0]    buf_360;
    logic          tx_en;
    logic          o_zone_valid;
    logic          o_zone_ready;
    logic [8:0]    o_zone_idx;
    logic [7:0]    o_zone_data;
    logic          o_zone_last;
    logic          o_frame_done;
    logic          o_busy;
    logic          o_short_err;
    logic          o_idx_err;
    logic [DW-1:0] o_drop_cnt;

    bl_zone_scheduler #(.DROP_W(DW)) dut (
        .i_pix_clk    (clk),
        .rst          (rst),
        .r_Vsync_0    (r_Vsync_0),
        .flag_done    (flag_done),
        .cnt_360      (cnt_360),
        .buf_360      (buf_360),
        .tx_en        (tx_en),
        .o_zone_valid (o_zone_valid),
        .o_zone_ready (o_zone_ready),
        .o_zone_idx   (o_zone_idx),
        .o_zone_data  (o_zone_data),
        .o_zone_last  (o_zone_last),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy),
        .o_short_err  (o_short_err),
        .o_idx_err    (o_idx_err),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] idx;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int done_cnt, short_cnt, idxerr_cnt, valid_cnt, beats;
    logic       hold_pending = 1'b0;
    logic [8:0] hold_idx;
    logic [7:0] hold_data;
    logic       hold_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fval(input int kind, input int i);
        int t;
        case (kind)
            0: t = i;
            1: t = i * 37 + 11;
            2: t = ~i;
            default: t = i + 7;
        endcase
        return t[7:0];
    endfunction

    task automatic clear_counts();
        done_cnt = 0; short_cnt = 0; idxerr_cnt = 0; valid_cnt = 0; beats = 0;
    endtask

    // Advance one clock, then monitor outputs and choose ready for the coming edge.
    task automatic tick();
        beat_t e;
        @(posedge clk);
        #1;
        if (hold_pending) begin
            chk("stall_valid", 32'(o_zone_valid), 32'(1'b1));
            chk("stall_idx", 32'(o_zone_idx), 32'(hold_idx));
            chk("stall_data", 32'(o_zone_data), 32'(hold_data));
            chk("stall_last", 32'(o_zone_last), 32'(hold_last));
            hold_pending = 1'b0;
        end
        if (o_frame_done) done_cnt++;
        if (o_short_err) short_cnt++;
        if (o_idx_err) idxerr_cnt++;
        if (o_zone_valid) valid_cnt++;
        case (ready_mode)
            0: o_zone_ready = 1'b1;
            1: o_zone_ready = 1'($urandom_range(0, 1));
            default: o_zone_ready = 1'b0;
        endcase
        if (o_zone_valid && o_zone_ready) begin
            if (sb.size() == 0) begin
                chk("stray_beat", 32'(o_zone_valid), 32'(1'b0));
            end else begin
                e = sb.pop_front();
                chk("beat_idx", 32'(o_zone_idx), 32'(e.idx));
                chk("beat_data", 32'(o_zone_data), 32'(e.data));
                chk("beat_last", 32'(o_zone_last), 32'(e.last));
            end
            beats++;
        end else if (o_zone_valid) begin
            hold_pending = 1'b1;
            hold_idx  = o_zone_idx;
            hold_data = o_zone_data;
            hold_last = o_zone_last;
        end
    endtask

    task automatic strobe(input int idx, input logic [7:0] val);
        flag_done = 1'b1;
        cnt_360   = 9'(idx);
        buf_360   = val;
        tick();
        flag_done = 1'b0;
    endtask

    task automatic write_frame(input int kind, input int skip);
        for (int i = 0; i < 360; i++) begin
            if (i != skip) strobe(i, fval(kind, i));
        end
    endtask

    task automatic push_frame(input int kind);
        for (int i = 0; i < 360; i++) begin
            sb.push_back('{idx: 9'(i), data: fval(kind, i), last: (i == 359)});
        end
    endtask

    task automatic vsync();
        r_Vsync_0 = 1'b1;
        tick();
        r_Vsync_0 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((o_busy || o_zone_valid) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_in_time"}, 32'(n < budget), 32'(1'b1));
        chk({tag, "_busy_low"}, 32'(o_busy), 32'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_zone_valid), 32'(1'b0));
        chk({tag, "_idx"}, 32'(o_zone_idx), 32'(9'd0));
        chk({tag, "_data"}, 32'(o_zone_data), 32'(8'd0));
        chk({tag, "_last"}, 32'(o_zone_last), 32'(1'b0));
        chk({tag, "_done"}, 32'(o_frame_done), 32'(1'b0));
        chk({tag, "_busy"}, 32'(o_busy), 32'(1'b0));
        chk({tag, "_short"}, 32'(o_short_err), 32'(1'b0));
        chk({tag, "_idxerr"}, 32'(o_idx_err), 32'(1'b0));
        chk({tag, "_drop"}, 32'(o_drop_cnt), 32'(0));
    endtask

    initial begin
        rst = 1'b1; r_Vsync_0 = 1'b0; flag_done = 1'b0; cnt_360 = '0; buf_360 = '0;
        tx_en = 1'b0; o_zone_ready = 1'b0;
        clear_counts();
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tx_en = 1'b1;
        tick();

        // Full frame, ready held high.
        write_frame(0, -1);
        clear_counts();
        push_frame(0);
        vsync();
        chk("launch_cycle_valid", 32'(o_zone_valid), 32'(1'b0));
        chk("launch_cycle_busy", 32'(o_busy), 32'(1'b1));
        tick();
        chk("first_valid", 32'(o_zone_valid), 32'(1'b1));
        chk("first_idx", 32'(o_zone_idx), 32'(9'd0));
        wait_idle("full", 400);
        chk("full_sb_empty", 32'(sb.size()), 32'(0));
        chk("full_frame_done", 32'(done_cnt), 32'(1));
        chk("full_valid_cycles", 32'(valid_cnt), 32'(360));
        chk("full_no_short", 32'(short_cnt), 32'(0));

        // Backpressure with pseudo-random ready.
        write_frame(1, -1);
        clear_counts();
        push_frame(1);
        ready_mode = 1;
        vsync();
        wait_idle("bp", 3000);
        ready_mode = 0;
        chk("bp_sb_empty", 32'(sb.size()), 32'(0));
        chk("bp_frame_done", 32'(done_cnt), 32'(1));
        chk("bp_beats", 32'(beats), 32'(360));

        // Complete frame with tx_en low is discarded silently.
        tx_en = 1'b0;
        write_frame(0, -1);
        clear_counts();
        vsync();
        repeat (5) tick();
        chk("txoff_no_valid", 32'(valid_cnt), 32'(0));
        chk("txoff_no_short", 32'(short_cnt), 32'(0));
        chk("txoff_drop", 32'(o_drop_cnt), 32'(0));
        tx_en = 1'b1;

        // Short frame: zone 200 missing.
        write_frame(2, 200);
        clear_counts();
        vsync();
        repeat (5) tick();
        chk("short_pulse", 32'(short_cnt), 32'(1));
        chk("short_no_valid", 32'(valid_cnt), 32'(0));
        chk("short_busy", 32'(o_busy), 32'(1'b0));

        // Out-of-range strobe ignored; last strobe coincides with the boundary.
        for (int i = 0; i < 359; i++) strobe(i, fval(3, i));
        clear_counts();
        strobe(360, 8'hEE);
        push_frame(3);
        flag_done = 1'b1; cnt_360 = 9'd359; buf_360 = fval(3, 359); r_Vsync_0 = 1'b1;
        tick();
        flag_done = 1'b0; r_Vsync_0 = 1'b0;
        wait_idle("coinc", 400);
        chk("coinc_idx_err", 32'(idxerr_cnt), 32'(1));
        chk("coinc_no_short", 32'(short_cnt), 32'(0));
        chk("coinc_frame_done", 32'(done_cnt), 32'(1));
        chk("coinc_sb_empty", 32'(sb.size()), 32'(0));

        // Overrun: frame A stalls while further complete frames arrive.
        ready_mode = 2;
        write_frame(2, -1);
        clear_counts();
        push_frame(2);
        vsync();
        tick();
        tick();
        chk("ovr_a_valid", 32'(o_zone_valid), 32'(1'b1));
        for (int k = 0; k < 9; k++) begin
            write_frame(3, -1);
            vsync();
            if (k == 0) chk("ovr_drop_one", 32'(o_drop_cnt), 32'(1));
        end
        tick();
        chk("ovr_drop_sat", 32'(o_drop_cnt), 32'((1 << DW) - 1));
        chk("ovr_a_intact", 32'(sb.size()), 32'(360));
        ready_mode = 0;
        wait_idle("ovr", 500);
        chk("ovr_sb_empty", 32'(sb.size()), 32'(0));
        chk("ovr_frame_done", 32'(done_cnt), 32'(1));

        // Reset at beat 100, then an empty frame.
        write_frame(0, -1);
        clear_counts();
        push_frame(0);
        vsync();
        begin
            int n = 0;
            while (beats < 100 && n < 500) begin
                tick();
                n++;
            end
            chk("rst_reach_beat100", 32'(n < 500), 32'(1'b1));
        end
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        sb.delete();
        hold_pending = 1'b0;
        tick();
        tick();
        check_all_zero("midrst_hold");
        rst = 1'b0;
        clear_counts();
        vsync();
        repeat (5) tick();
        chk("post_rst_short", 32'(short_cnt), 32'(1));
        chk("post_rst_no_valid", 32'(valid_cnt), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
